// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the two-requester 10G MAC TX arbiter.
package axis_arb_pkg;
  localparam int C_DATA_W    = 64;
  localparam int C_KEEP_W    = 8;
  localparam int C_PAYLOAD_W = C_DATA_W + C_KEEP_W + 2;
  localparam int C_LINK_WAIT = 63;
  localparam int C_CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;
endpackage

// File: rtl/axis_reg_slice.sv
// Two-entry skid buffer: registered valid/data toward the sink and a registered
// ready toward the source, so sink backpressure never reaches the source combinationally.
module axis_reg_slice #(
  parameter int DATA_W = 74
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_empty
);
  logic              r_out_vld;
  logic              r_skid_vld;
  logic              r_rdy;
  logic [DATA_W-1:0] r_out_data;
  logic [DATA_W-1:0] r_skid_data;
  logic              w_in_fire;
  logic              w_out_open;

  assign w_in_fire  = i_valid & r_rdy;
  assign w_out_open = ~r_out_vld | i_ready;

  // r_rdy is kept equal to "skid entry free" one edge ahead, so it is a plain flop
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
      r_rdy      <= 1'b0;
      r_out_data <= '0;
    end else if (w_out_open) begin
      r_rdy <= 1'b1;
      if (r_skid_vld) begin
        r_out_vld  <= 1'b1;
        r_out_data <= r_skid_data;
        r_skid_vld <= 1'b0;
      end else begin
        r_out_vld <= w_in_fire;
        if (w_in_fire) r_out_data <= i_data;
      end
    end else if (w_in_fire) begin
      r_skid_vld <= 1'b1;
      r_rdy      <= 1'b0;
    end else begin
      r_rdy <= ~r_skid_vld;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_in_fire && !w_out_open) r_skid_data <= i_data;
  end

  assign o_ready = r_rdy;
  assign o_valid = r_out_vld;
  assign o_data  = r_out_data;
  assign o_empty = ~r_out_vld & ~r_skid_vld;
endmodule

// File: rtl/axis_tx_arb.sv
// Frame-level round-robin arbiter merging two AXI-Stream requesters onto one
// 10G MAC TX port, gated by a link-up qualification counter.
module axis_tx_arb
  import axis_arb_pkg::*;
#(
  parameter int P_LINK_WAIT = C_LINK_WAIT,
  parameter int P_CNT_W     = C_CNT_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_link_up,
  input  logic                s0_axis_tvalid,
  output logic                s0_axis_tready,
  input  logic [C_DATA_W-1:0] s0_axis_tdata,
  input  logic                s0_axis_tlast,
  input  logic [C_KEEP_W-1:0] s0_axis_tkeep,
  input  logic                s0_axis_tuser,
  input  logic                s1_axis_tvalid,
  output logic                s1_axis_tready,
  input  logic [C_DATA_W-1:0] s1_axis_tdata,
  input  logic                s1_axis_tlast,
  input  logic [C_KEEP_W-1:0] s1_axis_tkeep,
  input  logic                s1_axis_tuser,
  output logic                m_axis_tx_tvalid,
  input  logic                m_axis_tx_tready,
  output logic [C_DATA_W-1:0] m_axis_tx_tdata,
  output logic                m_axis_tx_tlast,
  output logic [C_KEEP_W-1:0] m_axis_tx_tkeep,
  output logic                m_axis_tx_tuser,
  output logic [P_CNT_W-1:0]  o_frame_cnt0,
  output logic [P_CNT_W-1:0]  o_frame_cnt1,
  output logic                o_busy
);
  localparam int LW = (P_LINK_WAIT < 1) ? 1 : $clog2(P_LINK_WAIT + 1);

  arb_state_t             r_state;
  logic                   r_last;
  logic [LW-1:0]          r_link_cnt;
  logic [P_CNT_W-1:0]     r_cnt0;
  logic [P_CNT_W-1:0]     r_cnt1;
  logic                   w_grant_en;
  logic                   w_slice_rdy;
  logic                   w_slice_empty;
  logic                   w_fire0;
  logic                   w_fire1;
  logic                   w_in_vld;
  logic [C_PAYLOAD_W-1:0] w_in_data;
  logic [C_PAYLOAD_W-1:0] w_out_data;

  assign w_grant_en = (r_link_cnt == LW'(P_LINK_WAIT));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)           r_link_cnt <= '0;
    else if (!i_link_up) r_link_cnt <= '0;
    else if (!w_grant_en) r_link_cnt <= r_link_cnt + LW'(1);
  end

  assign s0_axis_tready = (r_state == GNT0) & w_slice_rdy;
  assign s1_axis_tready = (r_state == GNT1) & w_slice_rdy;
  assign w_fire0        = s0_axis_tvalid & s0_axis_tready;
  assign w_fire1        = s1_axis_tvalid & s1_axis_tready;

  always_comb begin
    w_in_vld  = 1'b0;
    w_in_data = {s0_axis_tdata, s0_axis_tkeep, s0_axis_tlast, s0_axis_tuser};
    case (r_state)
      GNT0: w_in_vld = s0_axis_tvalid;
      GNT1: begin
        w_in_vld  = s1_axis_tvalid;
        w_in_data = {s1_axis_tdata, s1_axis_tkeep, s1_axis_tlast, s1_axis_tuser};
      end
      default: ;
    endcase
  end

  // r_last names the requester that finished most recently; a tie goes to the other one
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_en) begin
            if (s0_axis_tvalid && s1_axis_tvalid) r_state <= r_last ? GNT0 : GNT1;
            else if (s0_axis_tvalid)              r_state <= GNT0;
            else if (s1_axis_tvalid)              r_state <= GNT1;
          end
        end
        GNT0: begin
          if (w_fire0 && s0_axis_tlast) begin
            r_state <= IDLE;
            r_last  <= 1'b0;
            r_cnt0  <= r_cnt0 + P_CNT_W'(1);
          end
        end
        GNT1: begin
          if (w_fire1 && s1_axis_tlast) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_cnt1  <= r_cnt1 + P_CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  axis_reg_slice #(.DATA_W(C_PAYLOAD_W)) u_slice (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (w_in_vld),
    .o_ready (w_slice_rdy),
    .i_data  (w_in_data),
    .o_valid (m_axis_tx_tvalid),
    .i_ready (m_axis_tx_tready),
    .o_data  (w_out_data),
    .o_empty (w_slice_empty)
  );

  assign {m_axis_tx_tdata, m_axis_tx_tkeep, m_axis_tx_tlast, m_axis_tx_tuser} = w_out_data;
  assign o_frame_cnt0 = r_cnt0;
  assign o_frame_cnt1 = r_cnt1;
  assign o_busy       = (r_state != IDLE) | ~w_slice_empty;
endmodule

// File: doc/axis_tx_arb.md
AXIS_TX_ARB -- requirements
Module: axis_tx_arb

Interface
REQ-001 The block SHALL have these parameters:
- P_LINK_WAIT, default 63: consecutive link-up cycles required before any grant.
- P_CNT_W, default 16: width of the per-port frame counters.

REQ-002 The block SHALL have these ports, in this order:
- i_clk  in  1  clock for all logic.
- i_rst  in  1  reset; asynchronous, active-high.
- i_link_up  in  1  MAC rx status, high means link up.
- s0_axis_tvalid/tready/tdata/tlast/tkeep/tuser  in/out/in/in/in/in  1/1/64/1/8/1  requester 0 frame stream.
- s1_axis_tvalid/tready/tdata/tlast/tkeep/tuser  in/out/in/in/in/in  1/1/64/1/8/1  requester 1 frame stream.
- m_axis_tx_tvalid/tready/tdata/tlast/tkeep/tuser  out/in/out/out/out/out  1/1/64/1/8/1  merged stream to the 10G MAC TX.
- o_frame_cnt0, o_frame_cnt1  out  P_CNT_W  completed frames forwarded per requester.
- o_busy  out  1  high while the block holds a grant or the output slice holds data.

Function
REQ-003 Link qualification SHALL use a counter that increments on each cycle with i_link_up=1, clears to 0 on any cycle with i_link_up=0, and saturates at P_LINK_WAIT.
- grant_en SHALL be 1 iff the counter equals P_LINK_WAIT.

REQ-004 The arbiter SHALL be an FSM with three states: IDLE, GNT0, GNT1.

REQ-005 IDLE transitions:
- If grant_en=1 and exactly one sN_axis_tvalid=1, go to GNTN.
- If both are valid, grant the requester that is not r_last.
- Otherwise stay in IDLE.

REQ-006 In IDLE, both s*_axis_tready SHALL be 0, so no beat is accepted.

REQ-007 In GNTn:
- sn_axis_tready SHALL equal the output slice's input ready.
- The other requester's tready SHALL be 0.
- Only sn data SHALL enter the slice.

REQ-008 When a beat with tlast=1 is accepted in GNTn:
- The FSM SHALL return to IDLE.
- r_last SHALL be set to n.
- o_frame_cnt<n> SHALL increment by 1, wrapping from all-ones to 0.

REQ-009 A grant is held until tlast. If i_link_up falls mid-frame, the current frame SHALL complete normally and no new grant SHALL be issued until grant_en returns to 1.

REQ-010 Throughput: at most one idle cycle (the IDLE decision cycle) SHALL occur between back-to-back frames. Within a frame, full rate (one beat per cycle) SHALL be sustained while m_axis_tx_tready=1.

REQ-011 The output slice SHALL have 2 entries and registered outputs.
- Latency from input accept to m_axis_tx_tvalid SHALL be 1 cycle.
- Input ready SHALL be registered, with no combinational path from m_axis_tx_tready to s*_axis_tready.

REQ-012 While m_axis_tx_tvalid=1 and m_axis_tx_tready=0, all m_axis_tx_* outputs SHALL hold stable.

REQ-013 tdata, tkeep, tlast and tuser SHALL be forwarded unmodified; byte ordering is the source's responsibility. Frames SHALL never interleave on the master port.

REQ-014 o_busy SHALL be (state != IDLE) OR (slice not empty).

REQ-015 If both requester tvalid signals rise in the same cycle as grant_en, the decision SHALL occur in that cycle and the grant SHALL take effect from the next cycle.

Reset
REQ-016 On i_rst=1, the following SHALL be forced immediately, without waiting for a clock edge:
- FSM = IDLE.
- r_last = 1, so s0 wins the first tie.
- Link counter = 0.
- Frame counters = 0.
- Slice emptied.
- All outputs = 0.

REQ-017 Reset asserted mid-frame SHALL drop the partial frame. After release, no grant SHALL be issued before P_LINK_WAIT qualified cycles.

Structure
REQ-018 Shared package axis_arb_pkg SHALL contain:
- The FSM state typedef (IDLE/GNT0/GNT1).
- Data width 64 and keep width 8 constants.
- P_LINK_WAIT and P_CNT_W defaults.

REQ-019 The output register slice SHALL be a sub-module, axis_reg_slice (2-entry skid buffer, 74-bit payload: tdata+tkeep+tlast+tuser). The arbiter FSM and counters SHALL live in axis_tx_arb.

Verification
REQ-020 Link qualify:
- Stimulus: i_link_up=1 with s0 valid.
- Required: s0_axis_tready stays 0 until cycle 64. First master beat appears 1 cycle after the first accept.
- Stimulus: a 1-cycle link-up drop at cycle 30.
- Required: the 64-cycle wait restarts.

REQ-021 Round robin:
- Stimulus: both requesters continuously send 4-beat frames, tready=1.
- Required: master order is s0,s1,s0,s1. Exactly 1 bubble between frames. Each frame counter is 2 after 4 frames.

REQ-022 Backpressure:
- Stimulus: m_axis_tx_tready toggled 1010 during an s1 frame of 186 beats with tdata = beat index.
- Required: all 186 beats arrive in order with no loss or duplication. Outputs stay stable while stalled. tlast appears only on beat 185.

REQ-023 Link drop mid-frame:
- Stimulus: i_link_up falls at beat 10 of a 20-beat s0 frame.
- Required: all 20 beats are forwarded. s1, pending, is not granted until 63 cycles after i_link_up returns high.

REQ-024 Counter wrap and reset:
- Stimulus: preload by sending 65536 one-beat s0 frames.
- Required: o_frame_cnt0 wraps to 0.
- Stimulus: assert i_rst mid-frame.
- Required: all outputs are 0 in the same cycle. o_busy=0.
